matrix_mul_seq: RTL and testbench

MATRIX_MUL_SEQ -- requirements
Module: matrix_mul_seq

---
 rtl/matmul_pkg.sv | 36 +++
 rtl/fx_dot_product.sv | 36 +++
 rtl/matrix_mul_seq.sv | 109 ++++++++++
 tb/tb_matrix_mul_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared FSM encoding and fixed-point helpers for matrix_mul_seq
package matmul_pkg;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CALC = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Arithmetic shift right; with rnd set, adds one half LSB first (round half up).
   function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                      input int unsigned frac,
                                                      input logic rnd);
      logic signed [63:0] t;
      t = v;
      if (rnd && frac != 0) t = t + (64'sd1 <<< (frac - 1));
      return t >>> frac;
   endfunction

   function automatic logic is_ovf(input logic signed [63:0] v, input int unsigned w);
      logic signed [63:0] mx, mn;
      mx = (64'sd1 <<< (w - 1)) - 64'sd1;
      mn = -(64'sd1 <<< (w - 1));
      return (v > mx) || (v < mn);
   endfunction

   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int unsigned w);
      logic signed [63:0] mx, mn;
      mx = (64'sd1 <<< (w - 1)) - 64'sd1;
      mn = -(64'sd1 <<< (w - 1));
      if (v > mx) return mx;
      if (v < mn) return mn;
      return v;
   endfunction

endpackage

// File: rtl/fx_dot_product.sv
// rtl/fx_dot_product.sv - combinational N-term signed fixed-point dot product with scaling and saturation
module fx_dot_product
   import matmul_pkg::*;
#(
   parameter int N     = 4,
   parameter int W     = 16,
   parameter int FRAC  = 8,
   parameter int ROUND = 0
) (
   input  logic [N-1:0][W-1:0] a_i,
   input  logic [N-1:0][W-1:0] b_i,
   output logic [W-1:0]        y_o,
   output logic                ovf_o
);

   localparam int AW = 2*W + $clog2(N);

   logic signed [2*W-1:0] prod [N];
   logic signed [AW-1:0]  acc;
   logic signed [63:0]    acc_ext;
   logic signed [63:0]    scaled;

   // Full-precision products summed without truncation; scaling happens once at the end.
   always_comb begin
      acc = '0;
      for (int k = 0; k < N; k++) begin
         prod[k] = $signed(a_i[k]) * $signed(b_i[k]);
         acc     = acc + {{(AW-2*W){prod[k][2*W-1]}}, prod[k]};
      end
      acc_ext = {{(64-AW){acc[AW-1]}}, acc};
      scaled  = round_shift(acc_ext, FRAC, ROUND != 0);
      ovf_o   = is_ovf(scaled, W);
      y_o     = W'(saturate(scaled, W));
   end

endmodule

// File: rtl/matrix_mul_seq.sv
// rtl/matrix_mul_seq.sv - sequential N x N fixed-point matrix multiplier, one result element per cycle
module matrix_mul_seq
   import matmul_pkg::*;
#(
   parameter int N     = 4,
   parameter int W     = 16,
   parameter int FRAC  = 8,
   parameter int ROUND = 0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N*N-1:0][W-1:0]  matA,
   input  logic [N*N-1:0][W-1:0]  matB,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N*N-1:0][W-1:0]  res_mat,
   output logic                   ovf
);

   localparam int NN = N*N;
   localparam int IW = $clog2(NN);

   state_t                 state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [NN-1:0][W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic                   ovf_q, ovf_d;
   logic                   out_valid_q, out_valid_d;
   logic [N-1:0][W-1:0]    a_row, b_col;
   logic [W-1:0]           dot_y;
   logic                   dot_ovf;

   always_comb begin : operand_select
      int row, col;
      row = int'(idx_q) / N;
      col = int'(idx_q) % N;
      for (int k = 0; k < N; k++) begin
         a_row[k] = a_q[IW'(row*N + k)];
         b_col[k] = b_q[IW'(k*N + col)];
      end
   end

   fx_dot_product #(.N(N), .W(W), .FRAC(FRAC), .ROUND(ROUND)) u_dot (
      .a_i   (a_row),
      .b_i   (b_col),
      .y_o   (dot_y),
      .ovf_o (dot_ovf)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      ovf_d       = ovf_q;
      out_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = matA;
               b_d     = matB;
               idx_d   = '0;
               ovf_d   = 1'b0;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            res_d[idx_q] = dot_y;
            ovf_d        = ovf_q | dot_ovf;
            idx_d        = idx_q + 1'b1;
            if (idx_q == IW'(NN-1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            // out_valid is registered, so it rises one cycle after DONE is entered.
            if (out_valid_q && out_ready) state_d = ST_IDLE;
            else                          out_valid_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = out_valid_q;
   assign res_mat   = res_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_matrix_mul_seq.sv
// tb/tb_matrix_mul_seq.sv - directed self-checking bench for matrix_mul_seq
module tb_matrix_mul_seq;

   localparam int N = 4;
   localparam int W = 16;
   typedef logic [N*N-1:0][W-1:0] mat_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   mat_t matA = '0;
   mat_t matB = '0;
   logic in_ready, out_valid, ovf;
   mat_t res_mat;
   logic in_ready_r, out_valid_r, ovf_r;
   mat_t res_mat_r;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   matrix_mul_seq #(.N(N), .W(W), .FRAC(8), .ROUND(0)) u_dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .matA(matA), .matB(matB), .out_valid(out_valid), .out_ready(out_ready),
      .res_mat(res_mat), .ovf(ovf)
   );

   matrix_mul_seq #(.N(N), .W(W), .FRAC(8), .ROUND(1)) u_dut_r (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_r),
      .matA(matA), .matB(matB), .out_valid(out_valid_r), .out_ready(out_ready),
      .res_mat(res_mat_r), .ovf(ovf_r)
   );

   function automatic mat_t fill(input logic [W-1:0] v);
      mat_t m;
      for (int i = 0; i < N*N; i++) m[i] = v;
      return m;
   endfunction

   function automatic mat_t diag(input logic [W-1:0] v);
      mat_t m;
      m = '0;
      for (int i = 0; i < N; i++) m[i*N+i] = v;
      return m;
   endfunction

   task automatic start_op(input mat_t a, input mat_t b);
      matA = a;
      matB = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (res_mat !== '0) begin miscompares++; $display("FAIL reset_res: got %h expected 0", res_mat); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
      reset_n = 1'b1;
      @(posedge clk); #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_scaling();
      int lat;
      start_op(fill(16'h0100), fill(16'h0200));
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL calc_in_ready: got %b expected 0", in_ready); end
      wait_done(lat);
      vectors++; if (lat !== 17) begin miscompares++; $display("FAIL scale_latency: got %0d expected 17", lat); end
      vectors++; if (res_mat !== fill(16'h0800)) begin miscompares++; $display("FAIL scale_res: got %h expected all 0800", res_mat); end
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL scale_ovf: got %b expected 0", ovf); end
      handshake();
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL scale_return_idle: got %b expected 1", in_ready); end
      start_op(fill(16'hFF00), fill(16'h0100));
      wait_done(lat);
      vectors++; if (res_mat !== fill(16'hFC00)) begin miscompares++; $display("FAIL negative_res: got %h expected all FC00", res_mat); end
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL negative_ovf: got %b expected 0", ovf); end
      handshake();
   endtask

   task automatic test_identity();
      int lat;
      mat_t b, exp2;
      b = {16'h0106, 16'h00FF, 16'h0404, 16'h0300, 16'hEDCC, 16'h1234, 16'hFFFF, 16'h0001,
           16'h8000, 16'h7000, 16'h0010, 16'hFE80, 16'h0FF0, 16'h01A3, 16'h0182, 16'h0159};
      start_op(diag(16'h0100), b);
      wait_done(lat);
      vectors++; if (res_mat !== b) begin miscompares++; $display("FAIL identity_res: got %h expected %h", res_mat, b); end
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL identity_ovf: got %b expected 0", ovf); end
      handshake();
      for (int i = 0; i < N*N; i++) begin
         b[i]    = 16'(16'h0100 + i*16'h0010);
         exp2[i] = 16'(16'h0200 + i*16'h0020);
      end
      start_op(diag(16'h0200), b);
      wait_done(lat);
      vectors++; if (res_mat !== exp2) begin miscompares++; $display("FAIL diag2_res: got %h expected %h", res_mat, exp2); end
      handshake();
   endtask

   task automatic test_saturation();
      int lat;
      start_op(fill(16'h7F00), fill(16'h7F00));
      wait_done(lat);
      vectors++; if (res_mat !== fill(16'h7FFF)) begin miscompares++; $display("FAIL sat_pos_res: got %h expected all 7FFF", res_mat); end
      vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL sat_pos_ovf: got %b expected 1", ovf); end
      handshake();
      start_op(fill(16'h7F00), fill(16'h8100));
      wait_done(lat);
      vectors++; if (res_mat !== fill(16'h8000)) begin miscompares++; $display("FAIL sat_neg_res: got %h expected all 8000", res_mat); end
      vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL sat_neg_ovf: got %b expected 1", ovf); end
      handshake();
   endtask

   task automatic test_rounding();
      int lat;
      mat_t a, b, e;
      a = '0; b = '0; e = '0;
      a[0] = 16'h0001;
      b[0] = 16'h0080;
      start_op(a, b);
      wait_done(lat);
      vectors++; if (res_mat !== e) begin miscompares++; $display("FAIL trunc_half_res: got %h expected %h", res_mat, e); end
      e[0] = 16'h0001;
      vectors++; if (res_mat_r !== e) begin miscompares++; $display("FAIL round_half_res: got %h expected %h", res_mat_r, e); end
      vectors++; if (out_valid_r !== 1'b1 || ovf_r !== 1'b0) begin miscompares++; $display("FAIL round_flags: got valid=%b ovf=%b expected valid=1 ovf=0", out_valid_r, ovf_r); end
      handshake();
      vectors++; if (in_ready_r !== 1'b1) begin miscompares++; $display("FAIL round_idle: got %b expected 1", in_ready_r); end
      a[0] = 16'hFFFF;
      start_op(a, b);
      wait_done(lat);
      e[0] = 16'hFFFF;
      vectors++; if (res_mat !== e) begin miscompares++; $display("FAIL trunc_neg_res: got %h expected %h", res_mat, e); end
      e[0] = 16'h0000;
      vectors++; if (res_mat_r !== e) begin miscompares++; $display("FAIL round_neg_res: got %h expected %h", res_mat_r, e); end
      handshake();
   endtask

   task automatic test_backpressure();
      int lat;
      start_op(fill(16'h0100), fill(16'h0200));
      wait_done(lat);
      matA = fill(16'h7F00);
      matB = fill(16'h7F00);
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid[%0d]: got %b expected 1", c, out_valid); end
         vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", c, in_ready); end
         vectors++; if (res_mat !== fill(16'h0800)) begin miscompares++; $display("FAIL hold_res[%0d]: got %h expected all 0800", c, res_mat); end
         vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL hold_ovf[%0d]: got %b expected 0", c, ovf); end
      end
      in_valid = 1'b0;
      handshake();
      vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
      vectors++; if (res_mat !== fill(16'h0800)) begin miscompares++; $display("FAIL idle_retain: got %h expected all 0800", res_mat); end
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL no_queue: got in_ready=%b expected 1", in_ready); end
   endtask

   task automatic test_reset_abort();
      int lat, seen;
      start_op(fill(16'h7F00), fill(16'h7F00));
      repeat (5) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      vectors++; if (res_mat !== '0) begin miscompares++; $display("FAIL abort_res: got %h expected 0", res_mat); end
      vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || ovf !== 1'b0) begin miscompares++; $display("FAIL abort_flags: got ready=%b valid=%b ovf=%b expected 1 0 0", in_ready, out_valid, ovf); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_no_valid: got %0d valid cycles expected 0", seen); end
      start_op(diag(16'h0100), fill(16'h0123));
      wait_done(lat);
      vectors++; if (lat !== 17) begin miscompares++; $display("FAIL post_abort_latency: got %0d expected 17", lat); end
      vectors++; if (res_mat !== fill(16'h0123)) begin miscompares++; $display("FAIL post_abort_res: got %h expected all 0123", res_mat); end
      handshake();
   endtask

   task automatic test_back_to_back();
      int lat;
      start_op(fill(16'h7F00), fill(16'h7F00));
      wait_done(lat);
      handshake();
      start_op(fill(16'hFF00), fill(16'h0100));
      wait_done(lat);
      vectors++; if (lat !== 17) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 17", lat); end
      vectors++; if (res_mat !== fill(16'hFC00)) begin miscompares++; $display("FAIL b2b_res: got %h expected all FC00", res_mat); end
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL b2b_ovf_cleared: got %b expected 0", ovf); end
      handshake();
   endtask

   initial begin
      test_reset();
      test_scaling();
      test_identity();
      test_saturation();
      test_rounding();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
